// File: rtl/arith_share_arbiter_if.sv
// Request/response bundle between two requesters and the shared add/sub arbiter.
// The master side drives the requests and response-ready; the slave side is the arbiter.
interface arith_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [3:0]       req_op0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [3:0]       req_op1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic             busy;

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/arith_share_arbiter.sv
// Round-robin shared add/sub unit for two requesters; accept -> rsp_valid in 2 cycles.
// Backpressure: no new request is accepted until the owning requester takes the response.
module arith_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  arith_share_arbiter_if.slave   io
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_prio;
  logic             r_id;
  opnd_t            r_opnd;
  opnd_t            w_sel;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;
  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_op_ok;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;

  // Only a contested cycle consults prio; a lone requester always wins.
  always_comb begin
    w_grant = 2'b00;
    case (io.req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  assign w_accept = |(io.req_valid & io.req_ready);
  assign w_sel    = w_grant[1] ? '{op: io.req_op1, a: io.req_a1, b: io.req_b1}
                               : '{op: io.req_op0, a: io.req_a0, b: io.req_b0};

  // SUB is A + ~B with the carry-in taken from opcode bit 1 (0 for ADD).
  assign w_op_ok = (r_opnd.op == OP_ADD) || (r_opnd.op == OP_SUB);
  assign w_b_eff = (r_opnd.op == OP_SUB) ? ~r_opnd.b : r_opnd.b;
  assign w_sum   = r_opnd.a + w_b_eff + {{(WIDTH-1){1'b0}}, r_opnd.op[1]};
  assign w_res   = w_op_ok ? w_sum : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (io.rsp_ready[r_id]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    io.req_ready = 2'b00;
    io.rsp_valid = 2'b00;
    io.busy      = 1'b0;
    if (r_state == S_IDLE && !i_rst) begin
      io.req_ready = w_grant;
    end
    if (r_state == S_RESP) begin
      io.rsp_valid = r_id ? 2'b10 : 2'b01;
    end
    if (r_state != S_IDLE) begin
      io.busy = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prio   <= 1'b0;
      r_id     <= 1'b0;
      r_opnd   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_opnd <= w_sel;
        r_id   <= w_grant[1];
      end
      if (r_state == S_EXEC) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_err    <= !w_op_ok;
      end
      if (r_state == S_RESP && io.rsp_ready[r_id]) begin
        r_prio <= ~r_id;
      end
    end
  end

  assign io.rsp_result = r_result;
  assign io.rsp_zero   = r_zero;
  assign io.rsp_err    = r_err;

endmodule

// File: tb/tb_arith_share_arbiter.sv
// Self-checking bench: vector table plus hand sequences, responses checked against a scoreboard queue.
module tb_arith_share_arbiter;

  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          zero;
    bit          err;
  } exp_t;

  typedef struct {
    bit          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    bit          zero;
    bit          err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  arith_share_arbiter_if #(.WIDTH(32)) bus();

  arith_share_arbiter #(.WIDTH(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", nm, $time);
  endtask

  function automatic exp_t model(input bit id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op);
    exp_t e;
    e.id = id;
    case (op)
      4'b0000: e.res = a + b;
      4'b0010: e.res = a - b;
      default: e.res = 32'd0;
    endcase
    e.err  = !(op == 4'b0000 || op == 4'b0010);
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Response side of the scoreboard: every completed handshake pops one expectation.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (|(bus.rsp_valid & bus.rsp_ready)) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_rsp");
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_valid", {30'd0, bus.rsp_valid}, mon_e.id ? 32'd2 : 32'd1);
        check("rsp_result", bus.rsp_result, mon_e.res);
        check("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, mon_e.zero});
        check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic set_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    if (id) begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op;
    end else begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
    end
  endtask

  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [31:0] er, input bit ez,
                      input bit ee, output int acc_cyc);
    bit accepted = 1'b0;
    int t = 0;
    acc_cyc = -1;
    set_req(id, a, b, op);
    bus.req_valid[id] = 1'b1;
    while (!accepted && t < 20) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        accepted = 1'b1;
        acc_cyc  = cyc;
        exp_q.push_back('{id: id, res: er, zero: ez, err: ee});
      end
      @(posedge clk);
      #1;
      t++;
    end
    bus.req_valid[id] = 1'b0;
    if (!accepted) fail_now("accept_timeout");
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   c0, c1, ng, t;
    bit   got[4];
    bit   g;

    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    set_req(0, 32'd0, 32'd0, 4'd0);
    set_req(1, 32'd0, 32'd0, 4'd0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_result", bus.rsp_result, 32'd0);
    check("rst_zero_err", {30'd0, bus.rsp_zero, bus.rsp_err}, 32'd0);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 2'b11;

    // Test 1: first-transaction timing
    set_req(0, 32'd5, 32'd7, 4'b0000);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("t1_req_ready", {30'd0, bus.req_ready}, 32'd1);
    if (bus.req_ready == 2'b01) exp_q.push_back('{id: 1'b0, res: 32'd12, zero: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t1_exec_no_rsp", {30'd0, bus.rsp_valid}, 32'd0);
    check("t1_exec_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("t1_rsp_after_2", {30'd0, bus.rsp_valid}, 32'd1);
    drain();

    // Table of single-requester operations
    vecs.push_back('{1'b1, 32'd3,          32'd3, 4'b0010, 32'd0,          1'b1, 1'b0});
    vecs.push_back('{1'b1, 32'd0,          32'd1, 4'b0010, 32'hFFFF_FFFF,  1'b0, 1'b0});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1, 4'b0000, 32'd0,          1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd9,          32'd4, 4'b0101, 32'd0,          1'b1, 1'b1});
    vecs.push_back('{1'b0, 32'd2,          32'd2, 4'b0000, 32'd4,          1'b0, 1'b0});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'h8000_0000, 4'b0000, 32'd0,  1'b1, 1'b0});
    vecs.push_back('{1'b0, 32'd1,          32'd1, 4'b1111, 32'd0,          1'b1, 1'b1});
    vecs.push_back('{1'b1, 32'd7,          32'd1, 4'b0011, 32'd0,          1'b1, 1'b1});
    vecs.push_back('{1'b1, 32'd100,        32'd58, 4'b0010, 32'd42,        1'b0, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op,
           vecs[i].res, vecs[i].zero, vecs[i].err, c0);
      drain();
    end

    // Test 3: both requesters valid continuously -> alternating grants
    set_req(0, 32'hFFFF_FFFF, 32'd1, 4'b0000);
    set_req(1, 32'd100, 32'd58, 4'b0010);
    bus.req_valid = 2'b11;
    ng = 0;
    t  = 0;
    while (ng < 4 && t < 40) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        g = bus.req_ready[1];
        got[ng] = g;
        exp_q.push_back(g ? model(1'b1, 32'd100, 32'd58, 4'b0010)
                          : model(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0000));
        ng++;
      end
      @(posedge clk); #1;
      t++;
    end
    bus.req_valid = 2'b00;
    if (ng < 4) fail_now("t3_grant_count");
    for (int i = 0; i < ng; i++) begin
      check($sformatf("t3_grant%0d", i), {31'd0, got[i]}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    drain();

    // Back-to-back from one requester: one accept every 3 cycles
    send(1'b0, 32'd1, 32'd2, 4'b0000, 32'd3, 1'b0, 1'b0, c0);
    send(1'b0, 32'd10, 32'd4, 4'b0010, 32'd6, 1'b0, 1'b0, c1);
    check("b2b_spacing", c1 - c0, 32'd3);
    drain();

    // Test 5: response held; only the non-owner's rsp_ready is high
    bus.rsp_ready = 2'b10;
    send(1'b0, 32'h1234, 32'd1, 4'b0000, 32'h1235, 1'b0, 1'b0, c0);
    set_req(1, 32'd20, 32'd5, 4'b0010);
    bus.req_valid = 2'b11;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      bus.req_a0 = 32'hA000 + k;
      @(negedge clk);
      check("t5_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
      check("t5_result", bus.rsp_result, 32'h1235);
      check("t5_req_ready", {30'd0, bus.req_ready}, 32'd0);
      check("t5_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    drain();

    // Test 6: async reset in EXEC, then prio restarts at requester 0
    send(1'b0, 32'd9, 32'd9, 4'b0000, 32'd18, 1'b0, 1'b0, c0);
    bus.req_valid = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    check("t6_result", bus.rsp_result, 32'd0);
    check("t6_zero_err", {30'd0, bus.rsp_zero, bus.rsp_err}, 32'd0);
    check("t6_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_req_ready", {30'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_prio_grant", {30'd0, bus.req_ready}, 32'd1);
    if (bus.req_ready == 2'b01) exp_q.push_back('{id: 1'b0, res: 32'd18, zero: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    send(1'b1, 32'd20, 32'd5, 4'b0010, 32'd15, 1'b0, 1'b0, c0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arith_share_arbiter.md
Name: arith_share_arbiter

Overview:
Shares one add/sub arithmetic datapath between two requesters (e.g. the execute stage and an address-generation unit). Uses round-robin arbitration with valid/ready handshakes on both request and response sides. Each granted operation's operands and opcode are latched before execution. The arbiter returns a registered result, zero flag and error flag to the winning requester. ALUop encoding matches the arithmetic part: 4'b0000 is ADD, 4'b0010 is SUB.

Parameters:
WIDTH, 32, operand/result width in bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  2  bit i: requester i presents an operation
req_ready  output  2  bit i: arbiter accepts requester i this cycle
req_a0  input  WIDTH  operand A, requester 0
req_b0  input  WIDTH  operand B, requester 0
req_op0  input  4  ALUop, requester 0
req_a1  input  WIDTH  operand A, requester 1
req_b1  input  WIDTH  operand B, requester 1
req_op1  input  4  ALUop, requester 1
rsp_valid  output  2  bit i: response for requester i is available
rsp_ready  input  2  bit i: requester i consumes the response
rsp_result  output  WIDTH  result of the completed operation (shared bus)
rsp_zero  output  1  rsp_result == 0
rsp_err  output  1  opcode was not ADD or SUB
busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. Register fields: prio (1 bit), id (1 bit), a_q, b_q, op_q.
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE and prio goes to 0; any in-flight transaction is dropped.
  - rsp_valid = 0, rsp_result = 0, rsp_zero = 0, rsp_err = 0, busy = 0.
  - req_ready is combinational and therefore 0 while reset is asserted.
- IDLE:
  - req_ready is one-hot or zero, computed combinationally.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester equal to prio is granted.
  - On req_valid[g] & req_ready[g]: latch a, b and op from requester g, set id = g, go to EXEC.
- EXEC (exactly 1 cycle):
  - ADD: rsp_result <= a_q + b_q.
  - SUB: rsp_result <= a_q + ~b_q + 1, two's complement, carry-in equal to op bit 1.
  - Any other op: rsp_result <= 0 and rsp_err <= 1.
  - Results wrap modulo 2^WIDTH; no carry or overflow output.
  - rsp_zero <= (next result == 0). An erroring op therefore also sets rsp_zero = 1.
  - Go to RESP.
- RESP:
  - rsp_valid[id] = 1 and the other bit = 0. rsp_result, rsp_zero and rsp_err are held stable.
  - On rsp_ready[id]: go to IDLE, set prio = ~id, clear rsp_valid.
  - rsp_ready on the non-owning bit is ignored.
  - Result, zero and err registers keep their last value after the handshake.
- Timing:
  - req_ready = 0 in EXEC and RESP; no new acceptance until the response is consumed.
  - Minimum latency from accept edge to rsp_valid is 2 cycles.
  - Peak throughput is one operation per 3 cycles.
- Boundary conditions:
  - Requester dropping req_valid while not granted: no effect.
  - Simultaneous requests after a requester-1 completion: prio is 0, so requester 0 wins.
  - Back-to-back requests from the same single requester: served every 3 cycles regardless of prio.
  - rsp_ready held high in advance: RESP lasts exactly 1 cycle.
  - Requester inputs may change after acceptance without affecting the result.

Test Plan:
1. Reset, then requester 0 sends op=0000, a=5, b=7 -> req_ready=01 in the same cycle; rsp_valid=01 two cycles later with rsp_result=12, zero=0, err=0.
2. Requester 1 sends op=0010, a=3, b=3 -> rsp_valid=10, result=0, zero=1. Then a=0, b=1, SUB -> result=32'hFFFFFFFF, zero=0.
3. Both requesters valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1; ADD 32'hFFFFFFFF+1 -> result=0, zero=1 (wrap).
4. Requester 0 sends op=0101 -> result=0, err=1, zero=1; a following ADD 2+2 -> result=4, err=0.
5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and result stay stable, req_ready stays 00, busy=1; change req_a0 during this time -> result unchanged.
6. Assert reset asynchronously mid-EXEC -> outputs are 0 immediately without a clock edge; after release, a new request from requester 1 with requester 0 also valid -> requester 0 is granted (prio=0).
